// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiters (read now, write later).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/axi_read_if.sv
// AXI read address and read data channel bundles used between caches and memory.
`include "mips_core.svh"

interface axi_read_address;
    logic                   arvalid;
    logic                   arready;
    logic [`ADDR_WIDTH-1:0] araddr;
    logic [7:0]             arlen;
    logic [3:0]             arid;

    modport master (output arvalid, output araddr, output arlen, output arid, input arready);
    modport slave  (input arvalid, input araddr, input arlen, output arready);
endinterface

interface axi_read_data;
    logic                   rvalid;
    logic                   rready;
    logic [`DATA_WIDTH-1:0] rdata;

    modport master (input rvalid, input rdata, output rready);
    modport slave  (output rvalid, output rdata, input rready);
endinterface

// File: rtl/mem_read_arbiter_chk.sv
// Simulation checker for the read arbiter's request inputs.
module mem_read_arbiter_chk #(
    parameter int MAX_BEATS = 16
) (
    input logic       clk,
    input logic       rst_n,
    input logic       i_arvalid,
    input logic [7:0] i_arlen,
    input logic       d_arvalid,
    input logic [7:0] d_arlen
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_BEATS);

    a_i_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        i_arvalid |-> (i_arlen <= MAX_LEN));

    a_d_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        d_arvalid |-> (d_arlen <= MAX_LEN));

endmodule

// File: rtl/mem_rr_grant.sv
// Two-input round-robin picker: one-hot grant, favouring the port not granted last.
module mem_rr_grant
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Pick the sole requester, or on a tie the port that did not win last time.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant == PORT_I) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_core.svh
// Core-wide bus widths shared by the cache refill paths and the memory port.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`endif

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI memory read port between the I- and D-cache
// refill masters; one burst outstanding, data beats routed back combinationally.
`include "mips_core.svh"

module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int         MAX_BEATS = 16,
    parameter logic [3:0] I_ARID    = 4'd0,
    parameter logic [3:0] D_ARID    = 4'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_read_address.slave  i_addr,
    axi_read_data.slave     i_data,
    axi_read_address.slave  d_addr,
    axi_read_data.slave     d_data,
    axi_read_address.master mem_addr,
    axi_read_data.master    mem_data
);

    localparam int             BW        = $clog2(MAX_BEATS) + 1;
    localparam logic [7:0]     MAX_LEN   = 8'(MAX_BEATS);
    localparam logic [BW-1:0]  ONE_BEAT  = BW'(1'b1);
    localparam logic [BW-1:0]  FULL_BEAT = BW'(MAX_BEATS);

    arb_state_e      state_r, state_nxt_s;
    logic            owner_r, owner_nxt_s;
    logic            last_grant_r, last_grant_nxt_s;
    logic [7:0]      len_r, len_nxt_s;
    logic [BW-1:0]   beats_left_r, beats_left_nxt_s;
    logic [BW-1:0]   load_beats_s;
    logic [1:0]      req_s, grant_s;
    logic            beat_s;

    logic                   mem_arvalid_s;
    logic [`ADDR_WIDTH-1:0] mem_araddr_s;
    logic [7:0]             mem_arlen_s;
    logic [3:0]             mem_arid_s;
    logic                   mem_rready_s;
    logic                   i_arready_s, d_arready_s;
    logic                   i_rvalid_s, d_rvalid_s;
    logic [`DATA_WIDTH-1:0] i_rdata_s, d_rdata_s;

    assign req_s = {d_addr.arvalid, i_addr.arvalid};

    mem_rr_grant u_rr_grant (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Burst length to count: zero means one beat, oversize clamps to the largest legal burst.
    always_comb begin
        load_beats_s = ONE_BEAT;
        if (len_r == 8'd0) begin
            load_beats_s = ONE_BEAT;
        end else if (len_r > MAX_LEN) begin
            load_beats_s = FULL_BEAT;
        end else begin
            load_beats_s = len_r[BW-1:0];
        end
    end

    assign beat_s = (state_r == ARB_DATA) & mem_data.rvalid & mem_rready_s;

    // Next-state logic for the grant FSM, owner/length latches and beat counter.
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_grant_nxt_s = last_grant_r;
        len_nxt_s        = len_r;
        beats_left_nxt_s = beats_left_r;
        case (state_r)
            ARB_IDLE: begin
                if (grant_s != 2'b00) begin
                    owner_nxt_s = grant_s[1] ? PORT_D : PORT_I;
                    len_nxt_s   = grant_s[1] ? d_addr.arlen : i_addr.arlen;
                    state_nxt_s = ARB_ADDR;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (mem_addr.arready) begin
                    state_nxt_s      = ARB_DATA;
                    beats_left_nxt_s = load_beats_s;
                    last_grant_nxt_s = owner_r;
                end else begin
                    state_nxt_s = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (beat_s) begin
                    beats_left_nxt_s = beats_left_r - ONE_BEAT;
                    // A counter that somehow reached zero also ends the burst rather than wrapping.
                    if (beats_left_r <= ONE_BEAT) begin
                        state_nxt_s = ARB_IDLE;
                    end else begin
                        state_nxt_s = ARB_DATA;
                    end
                end else begin
                    state_nxt_s = ARB_DATA;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Channel steering: address phase forwards the owner's request, data phase routes beats to the owner.
    always_comb begin
        mem_arvalid_s = 1'b0;
        mem_araddr_s  = '0;
        mem_arlen_s   = 8'd0;
        mem_arid_s    = 4'd0;
        mem_rready_s  = 1'b0;
        i_arready_s   = 1'b0;
        d_arready_s   = 1'b0;
        i_rvalid_s    = 1'b0;
        d_rvalid_s    = 1'b0;
        i_rdata_s     = '0;
        d_rdata_s     = '0;
        case (state_r)
            ARB_ADDR: begin
                mem_arvalid_s = 1'b1;
                if (owner_r == PORT_D) begin
                    mem_araddr_s = d_addr.araddr;
                    mem_arlen_s  = d_addr.arlen;
                    mem_arid_s   = D_ARID;
                    d_arready_s  = mem_addr.arready;
                end else begin
                    mem_araddr_s = i_addr.araddr;
                    mem_arlen_s  = i_addr.arlen;
                    mem_arid_s   = I_ARID;
                    i_arready_s  = mem_addr.arready;
                end
            end
            ARB_DATA: begin
                if (owner_r == PORT_D) begin
                    d_rvalid_s   = mem_data.rvalid;
                    d_rdata_s    = mem_data.rdata;
                    mem_rready_s = d_data.rready;
                end else begin
                    i_rvalid_s   = mem_data.rvalid;
                    i_rdata_s    = mem_data.rdata;
                    mem_rready_s = i_data.rready;
                end
            end
            default: begin
                mem_arvalid_s = 1'b0;
            end
        endcase
    end

    // State, latches and counter; synchronous reset drops any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ARB_IDLE;
            owner_r      <= PORT_I;
            last_grant_r <= PORT_D;
            len_r        <= 8'd0;
            beats_left_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            len_r        <= len_nxt_s;
            beats_left_r <= beats_left_nxt_s;
        end
    end

    assign mem_addr.arvalid = mem_arvalid_s;
    assign mem_addr.araddr  = mem_araddr_s;
    assign mem_addr.arlen   = mem_arlen_s;
    assign mem_addr.arid    = mem_arid_s;
    assign mem_data.rready  = mem_rready_s;
    assign i_addr.arready   = i_arready_s;
    assign d_addr.arready   = d_arready_s;
    assign i_data.rvalid    = i_rvalid_s;
    assign i_data.rdata     = i_rdata_s;
    assign d_data.rvalid    = d_rvalid_s;
    assign d_data.rdata     = d_rdata_s;

endmodule
